// File: rtl/io_bus_pkg.sv
// ---------------------------------------------------------------------------
// io_bus_pkg
// Shared definitions for the IO bus arbiter slice.
//   - bus_state_t : arbiter FSM states (IDLE, ACCESS, RESP)
//   - PORT_CPU / PORT_DMA : requester index constants (port 0 / port 1)
//   - WIDTH_* : access width encodings carried on widthN / io_width
// ---------------------------------------------------------------------------
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // 2'b11 is passed through untouched; IO targets treat it as a word.
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

endpackage

// File: rtl/io_arb_prio.sv
// ---------------------------------------------------------------------------
// io_arb_prio
// Winner selection for the two-port IO bus arbiter. Port 1 (DMA) has
// priority over port 0 (CPU).
//
// Build option: IO_BUS_ARBITER_STARVE_GUARD_EN
//   When defined, a saturating counter tracks consecutive port-1 wins taken
//   while port 0 was waiting; once it reaches STARVE_LIMIT, port 0 wins the
//   next contention. When undefined, priority is strictly port 1 and
//   STARVE_LIMIT has no effect.
//
// Ports:
//   clk_mem  in  1  clock
//   rst_n    in  1  asynchronous active-low reset (clears the counter)
//   idle     in  1  arbiter FSM is in IDLE (arbitration happens this cycle)
//   req0     in  1  port 0 request
//   req1     in  1  port 1 request
//   winner   out 1  selected port index (meaningful when any_req=1)
//   any_req  out 1  at least one request pending
// ---------------------------------------------------------------------------
module io_arb_prio
  import io_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_mem,
  input  logic rst_n,
  input  logic idle,
  input  logic req0,
  input  logic req1,
  output logic winner,
  output logic any_req
);

  assign any_req = req0 | req1;

`ifdef IO_BUS_ARBITER_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (int'(starve_cnt) >= STARVE_LIMIT);

  // Port 1 wins unless port 0 is waiting and has already been passed over
  // STARVE_LIMIT times in a row.
  always_comb begin
    winner = PORT_CPU;
    if (req1 && !(req0 && starved)) begin
      winner = PORT_DMA;
    end
  end

  // Counter only moves on arbitration (IDLE) cycles. It clears whenever
  // port 0 is not waiting or port 0 has just won, and saturates otherwise.
  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (!req0 || (winner == PORT_CPU)) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_ok;

  assign winner    = req1 ? PORT_DMA : PORT_CPU;
  assign unused_ok = &{1'b0, clk_mem, rst_n, idle, (STARVE_LIMIT > 0)};
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter
// Two-port (CPU = port 0, DMA = port 1) arbiter in front of a single IO
// register bus. Each access is IDLE (grant) -> ACCESS (IO strobe) ->
// RESP (completion strobe), so one access completes every three cycles.
//
// Build option: IO_BUS_ARBITER_STARVE_GUARD_EN enables the port-0
// starvation guard inside io_arb_prio.
//
// Ports (N in {0,1}):
//   clk_mem      in   1       clock, all state on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   reqN         in   1       access request
//   weN          in   1       1 = write, 0 = read
//   addrN        in   ADDR_W  byte address
//   wdataN       in   32      write data, right-aligned
//   widthN       in   2       00 byte, 01 halfword, 1x word
//   gntN         out  1       grant, combinational, IDLE only
//   rvalidN      out  1       one-cycle completion strobe
//   rdataN       out  32      read data (0 for writes), held between strobes
//   io_addr      out  ADDR_W  IO register address
//   io_data_in   out  32      IO write data
//   io_data_out  in   32      IO read data, combinational from io_addr
//   io_read      out  1       single-cycle read strobe
//   io_write     out  1       single-cycle write strobe
//   io_width     out  2       access width
// ---------------------------------------------------------------------------
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_mem,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  input  logic [1:0]        width0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  input  logic [1:0]        width1,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [31:0]       rdata0,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [31:0]       rdata1,
  output logic [ADDR_W-1:0] io_addr,
  output logic [31:0]       io_data_in,
  input  logic [31:0]       io_data_out,
  output logic              io_read,
  output logic              io_write,
  output logic [1:0]        io_width
);

  bus_state_t state;
  bus_state_t state_next;

  logic is_idle;
  logic winner;
  logic any_req;
  logic grant;
  logic lat_port;
  logic lat_we;

  assign is_idle = (state == ST_IDLE);
  assign grant   = gnt0 | gnt1;

  io_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk_mem (clk_mem),
    .rst_n   (rst_n),
    .idle    (is_idle),
    .req0    (req0),
    .req1    (req1),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes are decoded straight from the state so that reset, which forces
  // IDLE asynchronously, also drops them asynchronously. Grants are gated by
  // rst_n because the FSM sits in IDLE while reset is held.
  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    io_read    = 1'b0;
    io_write   = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any_req && rst_n) begin
          state_next = ST_ACCESS;
          gnt0       = (winner == PORT_CPU);
          gnt1       = (winner == PORT_DMA);
        end
      end
      ST_ACCESS: begin
        state_next = ST_RESP;
        io_read    = !lat_we;
        io_write   = lat_we;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        rvalid0    = (lat_port == PORT_CPU);
        rvalid1    = (lat_port == PORT_DMA);
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The winner's access fields are captured at the grant edge and drive the
  // IO bus directly, so io_addr/io_data_in/io_width hold their last values
  // until the next grant.
  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      lat_port   <= PORT_CPU;
      lat_we     <= 1'b0;
      io_addr    <= '0;
      io_data_in <= '0;
      io_width   <= '0;
    end else if (grant) begin
      lat_port <= winner;
      if (winner == PORT_DMA) begin
        lat_we     <= we1;
        io_addr    <= addr1;
        io_data_in <= wdata1;
        io_width   <= width1;
      end else begin
        lat_we     <= we0;
        io_addr    <= addr0;
        io_data_in <= wdata0;
        io_width   <= width0;
      end
    end
  end

  // Response registers per port: loaded at the end of ACCESS, presented
  // during RESP and held afterwards. Writes report zero.
  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ST_ACCESS) begin
      if (lat_port == PORT_DMA) begin
        rdata1 <= lat_we ? 32'h0 : io_data_out;
      end else begin
        rdata0 <= lat_we ? 32'h0 : io_data_out;
      end
    end
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, 24, address width of requester and IO-side address buses.
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive port-1 wins tolerated while port 0 waits (guard build only).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk_mem  in  1  memory/IO clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 reqN  in  1  access request, N in {0,1}; port 0 = CPU, port 1 = DMA.
REQ-007 weN  in  1  1 = write, 0 = read.
REQ-008 addrN  in  ADDR_W  byte address.
REQ-009 wdataN  in  32  write data, right-aligned.
REQ-010 widthN  in  2  00 byte, 01 halfword, 1x word.
REQ-011 gntN  out  1  grant; combinational, IDLE state only.
REQ-012 rvalidN  out  1  one-cycle completion strobe for reads and writes.
REQ-013 rdataN  out  32  read data, valid while rvalidN=1.
REQ-014 io_addr  out  ADDR_W  IO register address.
REQ-015 io_data_in  out  32  IO write data.
REQ-016 io_data_out  in  32  IO read data, combinational from io_addr.
REQ-017 io_read / io_write  out  1 each  single-cycle access strobes.
REQ-018 io_width  out  2  access width.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on any granted request; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-020 In IDLE, winner = port 1 if req1, else port 0 if req0; exactly one gntN high; access fields latched at the same edge.
REQ-021 Requester may deassert reqN in the cycle after gntN; an undropped request is re-arbitrated as a new access.
REQ-022 In ACCESS, io_* driven from latched fields; exactly one of io_read/io_write high for exactly one cycle; on a read, io_data_out captured into the response register.
REQ-023 In RESP, rvalid of the latched winner high for one cycle; rdata = captured data on reads, 0 on writes.
REQ-024 Latency: gnt at cycle T, IO strobe at T+1, rvalid at T+2; peak throughput one access per 3 cycles.
REQ-025 io_read and io_write never both high; outside ACCESS both are 0 and io_addr/io_data_in/io_width hold their last values.
REQ-026 widthN=11 passes through unchanged; the IO target treats it as word.
REQ-027 Requests arriving in ACCESS or RESP receive no grant until the next IDLE cycle.
REQ-028 rdataN holds its value between rvalid strobes.

Reset
REQ-029 rst_n low forces IDLE immediately; gnt*, rvalid*, io_read, io_write = 0; rdata*, io_addr, io_data_in, io_width, starvation counter = 0.
REQ-030 Reset during ACCESS/RESP aborts the access; no rvalid is issued for it after release.
REQ-031 First grant possible in the first IDLE cycle after rst_n deasserts.

Configuration
REQ-032 Macro IO_BUS_ARBITER_STARVE_GUARD_EN defined: saturating counter increments on each port-1 win while req0=1, clears on a port-0 win or when req0=0 in IDLE; at count = STARVE_LIMIT, port 0 wins the next contention.
REQ-033 Macro undefined: strict port-1 priority, no counter, STARVE_LIMIT ignored.

Structure
REQ-034 Shared package io_bus_pkg: FSM state enum, port index constants (PORT_CPU=0, PORT_DMA=1), width encodings.
REQ-035 One sub-module io_arb_prio: winner selection plus starvation counter; FSM and datapath remain in io_bus_arbiter.

Verification
REQ-036 req0 read addr=0x000100, width=10, io_data_out=0x00800005 -> gnt0 at T, io_read at T+1 with io_addr=0x000100, rvalid0 and rdata0=0x00800005 at T+2.
REQ-037 req0 and req1 both raised at T -> gnt1 at T, port 1 access completes first, gnt0 at T+3.
REQ-038 Guard build, STARVE_LIMIT=4, req0 and req1 held high -> four consecutive port-1 grants, then port-0 grant, then port 1 again.
REQ-039 Non-guard build, same stimulus -> port 0 never granted while req1 is high.
REQ-040 Write port 1 addr=0x000104 wdata=0x00C30000 width=01 -> io_write one cycle, io_data_in=0x00C30000, rvalid1 with rdata1=0 at T+2.
REQ-041 rst_n asserted during ACCESS -> io_read/io_write drop asynchronously, no rvalid after release, next request granted normally.
